nios_ii_system_cpu_debug_mailbox: RTL

Debug-memory stage directly downstream of the CPU's JTAG debug module. It consumes the system-clock-domain command strobes (`take_action_ocimem_*`, `take_no_action_ocimem_a`) and the 38-bit `jdo` payload, and executes word reads and writes on a private debug RAM. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug module. The CPU reaches the same RAM through a small Avalon-style slave port; JTAG commands always win arbitration.

---
 rtl/nios_ii_system_cpu_debug_mailbox.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/nios_ii_system_cpu_debug_mailbox.sv
// ---------------------------------------------------------------------------
// nios_ii_system_cpu_debug_mailbox
//
// Debug-memory stage that sits behind the JTAG debug module. The debug module
// hands it one-cycle command strobes plus a 38-bit payload (jdo), and this
// block executes single-word reads and writes against a private debug RAM.
// The CPU can reach the same RAM through a small Avalon-style slave port.
// JTAG commands always win arbitration, so the CPU is stalled while a command
// is in flight or being issued.
//
// Ports:
//   clk                     - system clock, the only clock
//   reset_n                 - synchronous active-low reset
//   jdo[37:0]               - command payload, valid while a strobe is high
//   take_action_ocimem_a    - set address (optionally followed by a read)
//   take_action_ocimem_b    - write jdo[34:3] at current address, increment
//   take_no_action_ocimem_a - read at current address, increment
//   MonDReg[31:0]           - data from the last JTAG read
//   monitor_ready           - last JTAG command has completed
//   monitor_error           - sticky, a command was dropped
//   cpu_address             - CPU word address
//   cpu_read / cpu_write    - CPU requests (both high is a write)
//   cpu_writedata[31:0]     - CPU write data
//   cpu_byteenable[3:0]     - CPU write byte lanes
//   cpu_readdata[31:0]      - CPU read data, one cycle after acceptance
//   cpu_waitrequest         - CPU stall (combinational)
// ---------------------------------------------------------------------------
module nios_ii_system_cpu_debug_mailbox #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CAP,
    WR
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] MonAReg;
  logic [31:0]       wdata_q;
  logic [31:0]       ram_q;
  logic [31:0]       mem [DEPTH];

  logic              any_strobe;
  logic              accept_a;
  logic              accept_b;
  logic              accept_na;
  logic              drop_cmd;
  logic              cpu_accept;
  logic              cpu_wr_acc;
  logic              cpu_rd_acc;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;

  // Payload bits above the command flags carry nothing for this stage.
  logic unused_jdo;
  assign unused_jdo = ^jdo[37:36];

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b |
                      take_no_action_ocimem_a;

  // JTAG owns the RAM whenever a command is in flight or being issued.
  assign cpu_waitrequest = (state_q != IDLE) | any_strobe;
  assign cpu_accept      = (cpu_read | cpu_write) & ~cpu_waitrequest;
  assign cpu_wr_acc      = cpu_write & cpu_accept;
  assign cpu_rd_acc      = cpu_read & ~cpu_write & cpu_accept;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and command decode. Only IDLE accepts a strobe; with several
  // strobes at once ocimem_b wins, then ocimem_a, and the losers are dropped.
  always_comb begin
    state_d   = state_q;
    accept_a  = 1'b0;
    accept_b  = 1'b0;
    accept_na = 1'b0;
    drop_cmd  = 1'b0;
    case (state_q)
      IDLE: begin
        if (take_action_ocimem_b) begin
          accept_b = 1'b1;
          state_d  = WR;
          drop_cmd = take_action_ocimem_a | take_no_action_ocimem_a;
        end else if (take_action_ocimem_a) begin
          accept_a = 1'b1;
          drop_cmd = take_no_action_ocimem_a;
          if (jdo[35]) begin
            state_d = RD;
          end
        end else if (take_no_action_ocimem_a) begin
          accept_na = 1'b1;
          state_d   = RD;
        end
      end
      RD: begin
        state_d  = CAP;
        drop_cmd = any_strobe;
      end
      CAP: begin
        state_d  = IDLE;
        drop_cmd = any_strobe;
      end
      WR: begin
        state_d  = IDLE;
        drop_cmd = any_strobe;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Single RAM port: the CPU drives it only in IDLE, otherwise JTAG uses
  // MonAReg. JTAG writes are always full-word.
  always_comb begin
    ram_addr  = MonAReg;
    ram_wdata = wdata_q;
    ram_be    = 4'h0;
    if (state_q == WR) begin
      ram_be = 4'hF;
    end else if (state_q == IDLE) begin
      ram_addr  = cpu_address;
      ram_wdata = cpu_writedata;
      if (cpu_wr_acc) begin
        ram_be = cpu_byteenable;
      end
    end
  end

  // Debug RAM. Contents survive reset; a write pending during reset is
  // simply not performed.
  always_ff @(posedge clk) begin
    ram_q <= mem[ram_addr];
    for (int i = 0; i < 4; i++) begin
      if (reset_n && ram_be[i]) begin
        mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
  end

  // Monitor registers and CPU read data. The drop-sets-error assignment comes
  // last so a dropped strobe wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      MonAReg       <= '0;
      MonDReg       <= '0;
      wdata_q       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      cpu_readdata  <= '0;
    end else begin
      if (accept_a) begin
        MonAReg       <= jdo[ADDR_W-1:0];
        monitor_ready <= ~jdo[35];
        if (jdo[34]) begin
          monitor_error <= 1'b0;
        end
      end
      if (accept_b) begin
        wdata_q       <= jdo[34:3];
        monitor_ready <= 1'b0;
      end
      if (accept_na) begin
        monitor_ready <= 1'b0;
      end
      if (state_q == CAP) begin
        MonDReg       <= ram_q;
        MonAReg       <= MonAReg + ADDR_W'(1);
        monitor_ready <= 1'b1;
      end
      if (state_q == WR) begin
        MonAReg       <= MonAReg + ADDR_W'(1);
        monitor_ready <= 1'b1;
      end
      if (drop_cmd) begin
        monitor_error <= 1'b1;
      end
      if (cpu_rd_acc) begin
        cpu_readdata <= mem[ram_addr];
      end
    end
  end

endmodule
